// File: rtl/mib_pkg.sv
// Shared widths, state encoding and timeout defaults for the MIB master.
// The master timeout is kept here next to the slave timeout it must exceed.
package mib_pkg;
    localparam int MIB_ADDR_BITS = 24;
    localparam int MIB_D_BITS    = 16;
    localparam int CMD_DATA_BITS = 32;

    localparam int                       SLV_CMD_ACK_TIMEOUT_CLKS = 16;
    localparam int                       MIB_ACK_TIMEOUT_CLKS     = 2 * SLV_CMD_ACK_TIMEOUT_CLKS;
    localparam logic [CMD_DATA_BITS-1:0] MIB_TIMEOUT_RDATA        = 32'hBAD0_BAD0;

    typedef enum logic [3:0] {
        IDLE,
        ADDR_HI,
        ADDR_LO,
        WDATA_HI,
        WDATA_LO,
        TURN,
        WAIT_ACK,
        RDATA_LO,
        DONE,
        TOUT
    } mib_state_e;
endpackage

// File: rtl/mib_master.sv
// Serialises 32-bit fmc_slave commands onto the 16-bit shared MIB bus.
// All bus and command outputs decode from the state register so reset drops them at once.
module mib_master
    import mib_pkg::*;
#(
    parameter int                       P_MIB_ACK_TIMEOUT_CLKS = MIB_ACK_TIMEOUT_CLKS,
    parameter logic [CMD_DATA_BITS-1:0] P_TIMEOUT_RDATA        = MIB_TIMEOUT_RDATA
) (
    input  logic                     i_sys_clk,
    input  logic                     i_sys_rst,
    input  logic                     i_cmd_sel,
    input  logic                     i_cmd_rd_wr_n,
    input  logic [MIB_ADDR_BITS-1:0] i_cmd_byte_addr,
    input  logic [CMD_DATA_BITS-1:0] i_cmd_wdata,
    output logic                     o_cmd_ack,
    output logic [CMD_DATA_BITS-1:0] o_cmd_rdata,
    output logic                     o_cmd_timeout,
    output logic                     o_busy,
    output logic                     o_mib_start,
    output logic                     o_mib_rd_wr_n,
    output logic [MIB_D_BITS-1:0]    o_mib_d,
    output logic                     o_mib_d_oe,
    input  logic [MIB_D_BITS-1:0]    i_mib_d,
    input  logic                     i_mib_slave_ack
);
    localparam int TW = $clog2(P_MIB_ACK_TIMEOUT_CLKS + 1);

    mib_state_e               state_q, state_d;
    logic                     sel_q, sel_dq;
    logic                     rd_q;
    logic [MIB_ADDR_BITS-1:0] addr_q;
    logic [CMD_DATA_BITS-1:0] wdata_q;
    logic [CMD_DATA_BITS-1:0] rdata_q;
    logic [TW-1:0]            timer_q;

    logic sel_rise, timer_last;
    assign sel_rise   = sel_q & ~sel_dq;
    assign timer_last = (timer_q == TW'(P_MIB_ACK_TIMEOUT_CLKS - 1));

    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            sel_dq  <= 1'b0;
            rd_q    <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= i_cmd_sel;
            sel_dq  <= sel_q;
            if (state_q == IDLE && sel_rise) begin
                rd_q    <= i_cmd_rd_wr_n;
                addr_q  <= i_cmd_byte_addr;
                wdata_q <= i_cmd_wdata;
                rdata_q <= '0;
            end
            if (state_q == TURN)
                timer_q <= '0;
            else if (state_q == WAIT_ACK)
                timer_q <= timer_q + 1'b1;
            if (state_q == WAIT_ACK && i_mib_slave_ack && rd_q)
                rdata_q[31:16] <= i_mib_d;
            if (state_q == RDATA_LO)
                rdata_q[15:0] <= i_mib_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (sel_rise) state_d = ADDR_HI;
            ADDR_HI:  state_d = ADDR_LO;
            ADDR_LO:  state_d = rd_q ? TURN : WDATA_HI;
            WDATA_HI: state_d = WDATA_LO;
            WDATA_LO: state_d = TURN;
            TURN:     state_d = WAIT_ACK;
            // ack takes priority over a coincident timeout
            WAIT_ACK: begin
                if (i_mib_slave_ack) state_d = rd_q ? RDATA_LO : DONE;
                else if (timer_last) state_d = TOUT;
            end
            RDATA_LO: state_d = DONE;
            DONE:     state_d = IDLE;
            TOUT:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        o_mib_start   = 1'b0;
        o_mib_d_oe    = 1'b0;
        o_mib_d       = '0;
        o_mib_rd_wr_n = (state_q == IDLE) ? 1'b1 : rd_q;
        o_cmd_ack     = 1'b0;
        o_cmd_timeout = 1'b0;
        o_cmd_rdata   = '0;
        o_busy        = (state_q != IDLE);
        case (state_q)
            ADDR_HI: begin
                o_mib_start = 1'b1;
                o_mib_d_oe  = 1'b1;
                o_mib_d     = {8'h00, addr_q[23:16]};
            end
            ADDR_LO: begin
                o_mib_d_oe = 1'b1;
                o_mib_d    = addr_q[15:0];
            end
            WDATA_HI: begin
                o_mib_d_oe = 1'b1;
                o_mib_d    = wdata_q[31:16];
            end
            WDATA_LO: begin
                o_mib_d_oe = 1'b1;
                o_mib_d    = wdata_q[15:0];
            end
            DONE: begin
                o_cmd_ack   = 1'b1;
                o_cmd_rdata = rd_q ? rdata_q : '0;
            end
            TOUT: begin
                o_cmd_ack     = 1'b1;
                o_cmd_timeout = 1'b1;
                o_cmd_rdata   = rd_q ? P_TIMEOUT_RDATA : '0;
            end
            default: ;
        endcase
    end
endmodule
